mul_div_unit: RTL and testbench

Iterative 32-bit unsigned multiply/divide unit for the EECS31L datapath. It takes two 32-bit register operands and produces one 32-bit result (product low/high word, quotient or remainder) over a fixed multi-cycle latency. Its `result` drives an operand input of the writeback/ALU-result 2:1 mux directly downstream. The control unit stalls on the `ready`/`done` handshake.

---
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mul_div_unit.sv | 82 ++++++++
 tb/tb_mul_div_unit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The requester drives the operands; the unit drives status and result.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, op_a, op_b,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, op, op_a, op_b,
    output ready, busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle.
// Multiply and divide share one {hi, lo} working register.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_div_unit_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] result_q;

  // Multiply: {carry,hi,lo}; divide: {rem[32:0],quo} in the same bits.
  always_comb begin
    addend  = acc[0] ? b_q : '0;
    sum     = acc[AW-1:WIDTH] + {1'b0, addend};
    trial   = acc[AW-1:WIDTH-1] - {2'b00, b_q};
    acc_nxt = acc;
    if (!op_q[1]) begin
      acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
    end else if (!trial[WIDTH+1]) begin
      acc_nxt = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {acc[AW-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu.start) begin
            state <= RUN;
            op_q  <= mdu.op;
            b_q   <= mdu.op_b;
            acc   <= {{(WIDTH+1){1'b0}}, mdu.op_a};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            state    <= DONE;
            // op[0] picks the high half: MULHU product-hi, REMU remainder
            result_q <= op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH]
                                : acc_nxt[WIDTH-1:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu.ready  = (state == IDLE);
  assign mdu.busy   = (state == RUN);
  assign mdu.done   = (state == DONE);
  assign mdu.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Each scenario task drives stimulus and checks its own results.
module tb_mul_div_unit;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mul_div_unit_if #(.WIDTH(32)) mdu ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (mdu.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat);
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.op    = o;
    mdu.op_a  = a;
    mdu.op_b  = b;
    @(posedge clk);
    #1;
    mdu.start = 1'b0;
    mdu.op_a  = 32'hDEAD_BEEF;
    mdu.op_b  = 32'h0BAD_F00D;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (mdu.done) begin
        lat = i;
        res = mdu.result;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mdu.start = 1'b0;
    mdu.op    = OP_MUL;
    mdu.op_a  = '0;
    mdu.op_b  = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (mdu.ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", mdu.ready);
    end
    tests++;
    if (mdu.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got %b want 0", mdu.busy);
    end
    tests++;
    if (mdu.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done got %b want 0", mdu.done);
    end
    tests++;
    if (mdu.result !== 32'h0) begin
      fails++;
      $display("FAIL reset_result got %h want 0", mdu.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int          lat;
    run_op(OP_MUL, 32'd7, 32'd6, r, lat);
    tests++;
    if (lat !== 32) begin
      fails++;
      $display("FAIL mul_latency got %0d want 32", lat);
    end
    tests++;
    if (r !== 32'h0000_002A) begin
      fails++;
      $display("FAIL mul_7x6 got %h want 0000002a", r);
    end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    tests++;
    if (r !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL mulhu_max got %h want fffffffe", r);
    end
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    tests++;
    if (r !== 32'h0000_0001) begin
      fails++;
      $display("FAIL mul_max got %h want 00000001", r);
    end
    tests++;
    if (mdu.ready !== 1'b1) begin
      fails++;
      $display("FAIL mul_idle_after got %b want 1", mdu.ready);
    end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int          lat;
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
    tests++;
    if (r !== 32'h0000_000E) begin
      fails++;
      $display("FAIL divu_100_7 got %h want 0000000e", r);
    end
    tests++;
    if (lat !== 32) begin
      fails++;
      $display("FAIL divu_latency got %0d want 32", lat);
    end
    run_op(OP_REMU, 32'd100, 32'd7, r, lat);
    tests++;
    if (r !== 32'h0000_0002) begin
      fails++;
      $display("FAIL remu_100_7 got %h want 00000002", r);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int          lat;
    run_op(OP_DIVU, 32'h1234_5678, 32'h0, r, lat);
    tests++;
    if (r !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL divu_by0 got %h want ffffffff", r);
    end
    run_op(OP_REMU, 32'h1234_5678, 32'h0, r, lat);
    tests++;
    if (r !== 32'h1234_5678) begin
      fails++;
      $display("FAIL remu_by0 got %h want 12345678", r);
    end
  endtask

  task automatic test_ignored_start();
    int          ndone;
    logic [31:0] r;
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.op    = OP_MUL;
    mdu.op_a  = 32'd3;
    mdu.op_b  = 32'd5;
    @(posedge clk);
    #1;
    mdu.start = 1'b0;
    ndone = 0;
    r     = 'x;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      mdu.start = 1'b0;
      if (mdu.done) begin
        ndone++;
        r = mdu.result;
      end
      if (i == 10) begin
        mdu.start = 1'b1;
        mdu.op    = OP_DIVU;
        mdu.op_a  = 32'd100;
        mdu.op_b  = 32'd7;
      end
    end
    tests++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL ign_done_count got %0d want 1", ndone);
    end
    tests++;
    if (r !== 32'h0000_000F) begin
      fails++;
      $display("FAIL ign_result got %h want 0000000f", r);
    end
    tests++;
    if (mdu.ready !== 1'b1 || mdu.busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_idle got ready=%b busy=%b want 1/0",
               mdu.ready, mdu.busy);
    end
  endtask

  task automatic test_reset_mid();
    int          ndone;
    logic [31:0] r;
    int          lat;
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.op    = OP_DIVU;
    mdu.op_a  = 32'hFFFF_FFFF;
    mdu.op_b  = 32'd3;
    @(posedge clk);
    #1;
    mdu.start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests++;
    if (mdu.ready !== 1'b1 || mdu.busy !== 1'b0 || mdu.done !== 1'b0) begin
      fails++;
      $display("FAIL rmid_state got r=%b b=%b d=%b want 1/0/0",
               mdu.ready, mdu.busy, mdu.done);
    end
    tests++;
    if (mdu.result !== 32'h0) begin
      fails++;
      $display("FAIL rmid_result got %h want 0", mdu.result);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mdu.done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL rmid_no_done got %0d want 0", ndone);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, r, lat);
    tests++;
    if (r !== 32'h0000_0003) begin
      fails++;
      $display("FAIL rmid_div_9_3 got %h want 00000003", r);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.op    = OP_MUL;
    mdu.op_a  = 32'd7;
    mdu.op_b  = 32'd6;
    for (int i = 0; i <= 66; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        tests++;
        if (mdu.busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_busy0 got %b want 1", mdu.busy);
        end
      end
      if (i == 32) begin
        tests++;
        if (mdu.done !== 1'b1 || mdu.result !== 32'd42) begin
          fails++;
          $display("FAIL b2b_first got done=%b res=%h want 1/0000002a",
                   mdu.done, mdu.result);
        end
      end
      if (i == 33) begin
        tests++;
        if (mdu.ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready33 got %b want 1", mdu.ready);
        end
        mdu.op_a = 32'd10;
        mdu.op_b = 32'd10;
      end
      if (i == 34) begin
        tests++;
        if (mdu.busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_accept34 got %b want 1", mdu.busy);
        end
        mdu.start = 1'b0;
      end
      if (i == 66) begin
        tests++;
        if (mdu.done !== 1'b1 || mdu.result !== 32'd100) begin
          fails++;
          $display("FAIL b2b_second got done=%b res=%h want 1/00000064",
                   mdu.done, mdu.result);
        end
      end
    end
    mdu.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    mdu.start = 1'b0;
    mdu.op    = OP_MUL;
    mdu.op_a  = '0;
    mdu.op_b  = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
